// File: rtl/ext_load_scheduler_pkg.sv
// Shared types and constants for the external-load scheduler: load IDs,
// request/issue records and the AGU starvation limit.
package ext_load_scheduler_pkg;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int MAX_OUTST  = 4;
  localparam int IDW        = $clog2(MAX_OUTST);
  localparam int STARVE_LIM = 8;
  localparam int STARVE_W   = $clog2(STARVE_LIM + 1);

  typedef logic [IDW-1:0] EXT_LD_ID;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
  } ext_ld_req_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    EXT_LD_ID          id;
  } ext_ld_t;

  function automatic int minInt(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/ext_load_scheduler_if.sv
// Request, issue and response signals between external requesters, the
// scheduler and the load pipeline.
interface ext_load_scheduler_if #(
  parameter int NUM_REQ   = 2,
  parameter int NUM_PORTS = 2
);
  import ext_load_scheduler_pkg::*;

  logic [NUM_REQ-1:0]               IN_reqValid;
  logic [NUM_REQ-1:0][ADDR_W-1:0]   IN_reqAddr;
  logic [NUM_REQ-1:0]               OUT_reqReady;
  logic [NUM_PORTS-1:0]             OUT_extLdValid;
  logic [NUM_PORTS-1:0][ADDR_W-1:0] OUT_extLdAddr;
  logic [NUM_PORTS-1:0][IDW-1:0]    OUT_extLdId;
  logic [NUM_PORTS-1:0]             IN_ldStall;
  logic [NUM_PORTS-1:0]             IN_aguLdValid;
  logic                             IN_resValid;
  logic [IDW-1:0]                   IN_resId;
  logic [DATA_W-1:0]                IN_resData;
  logic [NUM_REQ-1:0]               OUT_resValid;
  logic [DATA_W-1:0]                OUT_resData;

  modport master (
    output IN_reqValid, IN_reqAddr, IN_ldStall, IN_aguLdValid,
           IN_resValid, IN_resId, IN_resData,
    input  OUT_reqReady, OUT_extLdValid, OUT_extLdAddr, OUT_extLdId,
           OUT_resValid, OUT_resData
  );

  modport slave (
    input  IN_reqValid, IN_reqAddr, IN_ldStall, IN_aguLdValid,
           IN_resValid, IN_resId, IN_resData,
    output OUT_reqReady, OUT_extLdValid, OUT_extLdAddr, OUT_extLdId,
           OUT_resValid, OUT_resData
  );

endinterface

// File: rtl/ext_load_scheduler_rr.sv
// Combinational round-robin arbiter granting up to 'limit' of N requesters.
// Slot k carries the k-th winner in search order starting at ptr.
module rr_multi_grant #(
  parameter  int N    = 2,
  parameter  int M    = 2,
  localparam int IDXW = (N > 1) ? $clog2(N) : 1,
  localparam int CNTW = $clog2(M + 1)
) (
  input  logic [N-1:0]            req,
  input  logic [IDXW-1:0]         ptr,
  input  logic [CNTW-1:0]         limit,
  output logic [N-1:0]            grant,
  output logic [M-1:0]            slotValid,
  output logic [M-1:0][IDXW-1:0]  slotIdx,
  output logic                    anyGrant,
  output logic [IDXW-1:0]         lastIdx
);

  always_comb begin
    int cnt;
    int idx;
    grant     = '0;
    slotValid = '0;
    slotIdx   = '0;
    anyGrant  = 1'b0;
    lastIdx   = '0;
    cnt       = 0;
    idx       = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (req[idx] && cnt < int'(limit) && cnt < M) begin
        grant[idx]     = 1'b1;
        slotValid[cnt] = 1'b1;
        slotIdx[cnt]   = IDXW'(idx);
        anyGrant       = 1'b1;
        lastIdx        = IDXW'(idx);
        cnt            = cnt + 1;
      end
    end
  end

endmodule

// File: rtl/ext_load_scheduler.sv
// Schedules external (non-AGU) loads onto per-port issue registers, tracks
// them in an ID table so results route back, and throttles ports starving AGUs.
module ext_load_scheduler
  import ext_load_scheduler_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int NUM_PORTS = 2
) (
  input logic               clk,
  input logic               rst,
  ext_load_scheduler_if.slave bus
);

  localparam int IDXW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PORTW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CNTW  = $clog2(NUM_PORTS + 1);

  ext_ld_t                        issueReg [NUM_PORTS];
  logic [STARVE_W-1:0]            starveCnt [NUM_PORTS];
  logic [MAX_OUTST-1:0]           tabBusy;
  logic [IDXW-1:0]                tabOwner [MAX_OUTST];
  logic [IDXW-1:0]                rrPtr;
  logic [NUM_REQ-1:0]             resValidQ;
  logic [DATA_W-1:0]              resDataQ;

  ext_ld_req_t                    reqs [NUM_REQ];
  logic [NUM_REQ-1:0]             reqVld;
  logic [NUM_PORTS-1:0]           portFree;
  logic [NUM_PORTS-1:0][PORTW-1:0] slotPort;
  logic [NUM_PORTS-1:0][IDW-1:0]  slotId;
  logic [CNTW-1:0]                grantLimit;

  logic [NUM_REQ-1:0]             grant;
  logic [NUM_PORTS-1:0]           slotValid;
  logic [NUM_PORTS-1:0][IDXW-1:0] slotIdx;
  logic                           anyGrant;
  logic [IDXW-1:0]                lastIdx;

  for (genvar r = 0; r < NUM_REQ; r++) begin : g_req
    assign reqs[r] = '{valid: bus.IN_reqValid[r], addr: bus.IN_reqAddr[r]};
    assign reqVld[r] = reqs[r].valid;
  end

  // Slot k maps to the k-th lowest free port and the k-th lowest free ID.
  always_comb begin
    int nPort;
    int nId;
    nPort    = 0;
    nId      = 0;
    portFree = '0;
    slotPort = '0;
    slotId   = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      portFree[p] = (starveCnt[p] != STARVE_W'(STARVE_LIM)) &&
                    (!issueReg[p].valid || !bus.IN_ldStall[p]);
      if (portFree[p]) begin
        if (nPort < NUM_PORTS) slotPort[nPort] = PORTW'(p);
        nPort = nPort + 1;
      end
    end
    for (int i = 0; i < MAX_OUTST; i++) begin
      if (!tabBusy[i]) begin
        if (nId < NUM_PORTS) slotId[nId] = IDW'(i);
        nId = nId + 1;
      end
    end
    grantLimit = rst ? '0 : CNTW'(minInt(nPort, nId));
  end

  rr_multi_grant #(.N(NUM_REQ), .M(NUM_PORTS)) u_rr (
    .req      (reqVld),
    .ptr      (rrPtr),
    .limit    (grantLimit),
    .grant    (grant),
    .slotValid(slotValid),
    .slotIdx  (slotIdx),
    .anyGrant (anyGrant),
    .lastIdx  (lastIdx)
  );

  // A reload in the draining cycle overrides the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < NUM_PORTS; p++) issueReg[p] <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (!bus.IN_ldStall[p]) issueReg[p].valid <= 1'b0;
      end
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (slotValid[k]) begin
          issueReg[slotPort[k]] <= '{valid: 1'b1,
                                     addr:  reqs[slotIdx[k]].addr,
                                     id:    slotId[k]};
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < NUM_PORTS; p++) starveCnt[p] <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (issueReg[p].valid && bus.IN_aguLdValid[p]) begin
          if (starveCnt[p] != STARVE_W'(STARVE_LIM)) starveCnt[p] <= starveCnt[p] + 1'b1;
        end else begin
          starveCnt[p] <= '0;
        end
      end
    end
  end

  // Responses only free busy IDs; grants only take free IDs, so they never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tabBusy   <= '0;
      for (int i = 0; i < MAX_OUTST; i++) tabOwner[i] <= '0;
      rrPtr     <= '0;
      resValidQ <= '0;
      resDataQ  <= '0;
    end else begin
      resValidQ <= '0;
      if (bus.IN_resValid && tabBusy[bus.IN_resId]) begin
        tabBusy[bus.IN_resId]          <= 1'b0;
        resValidQ[tabOwner[bus.IN_resId]] <= 1'b1;
        resDataQ                       <= bus.IN_resData;
      end
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (slotValid[k]) begin
          tabBusy[slotId[k]]  <= 1'b1;
          tabOwner[slotId[k]] <= slotIdx[k];
        end
      end
      if (anyGrant) rrPtr <= (int'(lastIdx) == NUM_REQ - 1) ? '0 : lastIdx + 1'b1;
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign bus.OUT_extLdValid[p] = issueReg[p].valid;
    assign bus.OUT_extLdAddr[p]  = issueReg[p].addr;
    assign bus.OUT_extLdId[p]    = issueReg[p].id;
  end

  assign bus.OUT_reqReady = grant;
  assign bus.OUT_resValid = resValidQ;
  assign bus.OUT_resData  = resDataQ;

endmodule

// File: doc/ext_load_scheduler.md
Name: ext_load_scheduler

Overview:
Schedules non-AGU ("external") loads from several requesters, such as page walkers or a prefetcher, onto the per-AGU external-load slots of the load mux. Those slots always pre-empt AGU loads.
- Round-robin arbitration between requesters.
- Per-port issue registers that hold a load until the load pipeline accepts it.
- A bounded outstanding-load table with IDs, so responses route back to their requester.
- Starvation guard so AGU loads are not locked out indefinitely.

Parameters:
NUM_REQ, 2, number of external load requesters
NUM_PORTS, 2, number of load ports (equals NUM_AGUS)
ADDR_W, 32, load address width
MAX_OUTST, 4, outstanding-table entries (power of two); ID width is IDW = log2(MAX_OUTST)
STARVE_LIM, 8, consecutive cycles an external load may block a valid AGU load before that port is throttled

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
IN_reqValid  in  NUM_REQ  request valid per requester
IN_reqAddr  in  NUM_REQ x ADDR_W  request address
OUT_reqReady  out  NUM_REQ  request accepted this cycle (valid-and-ready handshake)
OUT_extLdValid  out  NUM_PORTS  external load valid toward the load mux
OUT_extLdAddr  out  NUM_PORTS x ADDR_W  external load address
OUT_extLdId  out  NUM_PORTS x IDW  outstanding-table ID carried with the load
IN_ldStall  in  NUM_PORTS  load pipeline stall per port
IN_aguLdValid  in  NUM_PORTS  AGU load pending on the port (starvation monitoring)
IN_resValid  in  1  load result valid
IN_resId  in  IDW  result ID
IN_resData  in  32  result data
OUT_resValid  out  NUM_REQ  result delivered to requester
OUT_resData  out  32  result data, broadcast to all requesters

Behaviour:
- Reset, asynchronous, takes effect immediately:
  - all issue registers invalid; OUT_extLdValid=0.
  - outstanding table all free; RR pointer=0; starvation counters=0.
  - OUT_reqReady=0; OUT_resValid=0; OUT_resData=0.
  - Reset mid-operation discards in-flight loads. Later responses with stale IDs are dropped because the table is all free.
- Port free: a port is free when its issue register is invalid, or it is valid and IN_ldStall=0 this cycle (it drains this cycle). A port is not free while it is throttled.
- Arbitration, combinational, per cycle:
  - grant up to min(free ports, free table entries) requesters.
  - search order starts at the RR pointer and proceeds ascending with wrap.
  - the k-th granted requester takes the k-th lowest free port and the k-th lowest free table ID.
  - OUT_reqReady[r]=1 only for granted r; OUT_reqReady never depends on OUT_reqReady (no combinational loop).
- Accept edge:
  - issue register[p] <= {valid, addr, id}.
  - table[id] <= {busy, owner=r}.
  - RR pointer <= (last granted requester + 1) mod NUM_REQ; pointer unchanged when nothing is granted.
- Issue registers: outputs drive directly from the registers, so latency from request acceptance to OUT_extLdValid is 1 cycle. A register holds stable while IN_ldStall=1. It clears when IN_ldStall=0, unless it is reloaded the same cycle.
- Responses:
  - IN_resValid with busy table[IN_resId]: OUT_resValid[owner]=1 and OUT_resData=IN_resData, both registered, 1-cycle latency.
  - the entry frees at that edge and can be granted the following cycle, not the same one.
  - a response to a free ID is ignored; OUT_resValid stays 0.
  - a response arriving in the same cycle as a grant can never target the ID being granted, because only free IDs are granted.
- Starvation guard, per port:
  - counter increments each cycle OUT_extLdValid[p] && IN_aguLdValid[p]; resets to 0 otherwise. It saturates at STARVE_LIM.
  - at STARVE_LIM the port is throttled: no new grant is loaded into it.
  - throttling ends, and the counter clears, once IN_aguLdValid[p]=0 or OUT_extLdValid[p]=0 for one cycle.
  - an already-valid issue register is never dropped by throttling.
- Table full: no grants; OUT_reqReady=0 for all requesters.
- Simultaneous full table and response: the freed entry becomes grantable next cycle.

Decomposition:
- Shared package: EXT_LD_ID type (IDW bits), ext_ld_req_t {valid, addr}, ext_ld_t {valid, addr, id}, and constant STARVE_LIM.
- Sub-module rr_multi_grant: combinational round-robin N-of-M grant with pointer input and grant-index outputs. It is reusable by other arbiters in the codebase.
- The outstanding table and issue registers remain inline.

Test Plan:
- Single request: r0 addr 0x1000, no stall -> OUT_reqReady[0]=1 at cycle 0; OUT_extLdValid[0]=1, addr 0x1000, id 0 at cycle 1. IN_resValid id 0, data 0xDEADBEEF -> OUT_resValid[0]=1 with that data the next cycle; entry 0 free.
- Round-robin with NUM_PORTS=1: r0 and r1 both valid every cycle -> grants alternate r0, r1, r0, r1; IDs 0, 1, 2, 3; grants then stop (table full) until a response frees an entry.
- Stall hold: IN_ldStall[0]=1 for 5 cycles -> OUT_extLdAddr[0] stays constant. Port 1 keeps accepting new requests. Port 0 drains on the first cycle with no stall.
- Starvation: IN_aguLdValid[0]=1 with continuous r0 traffic on a single port -> after 8 blocking cycles no grant for port 0. The AGU load proceeds once the register drains, and grants resume after the counter clears.
- Response to a free ID 3 -> no OUT_resValid. rst asserted with 2 loads outstanding -> outputs 0 immediately; post-reset responses for IDs 0 and 1 are ignored.
